// File: rtl/user_tree_pkg.sv
// Shared definitions for the protobuf field encoder: wire types, data-type bit
// positions, encoder FSM states and the field-type decode helpers.
package user_tree_pkg;

    localparam logic [2:0] WT_VARINT = 3'd0;
    localparam logic [2:0] WT_I64    = 3'd1;
    localparam logic [2:0] WT_LEN    = 3'd2;
    localparam logic [2:0] WT_I32    = 3'd5;

    localparam int DT_FIXED32_BIT = 0;
    localparam int DT_FIXED64_BIT = 1;
    localparam int DT_VARINT_BIT  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEY,
        ST_VARINT,
        ST_FIXED,
        ST_LEN,
        ST_PAYLOAD
    } enc_state_t;

    typedef enum logic [1:0] {
        KIND_VARINT,
        KIND_I64,
        KIND_I32,
        KIND_LEN
    } field_kind_t;

    // Varint outranks fixed64, which outranks fixed32; no bits set means length-delimited.
    function automatic field_kind_t decode_kind(input logic [2:0] field_type);
        field_kind_t kind;
        if (field_type[DT_VARINT_BIT]) begin
            kind = KIND_VARINT;
        end else if (field_type[DT_FIXED64_BIT]) begin
            kind = KIND_I64;
        end else if (field_type[DT_FIXED32_BIT]) begin
            kind = KIND_I32;
        end else begin
            kind = KIND_LEN;
        end
        return kind;
    endfunction

    function automatic logic [2:0] kind_wire_type(input field_kind_t kind);
        logic [2:0] wt;
        wt = WT_VARINT;
        case (kind)
            KIND_VARINT: wt = WT_VARINT;
            KIND_I64:    wt = WT_I64;
            KIND_I32:    wt = WT_I32;
            KIND_LEN:    wt = WT_LEN;
            default:     wt = WT_VARINT;
        endcase
        return wt;
    endfunction

endpackage

// File: rtl/proto_varint_serializer.sv
// Base-128 varint byte generator: load a value, emit 7-bit groups LSB first with
// the continuation bit, hold the current byte while the consumer stalls.
module proto_varint_serializer #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] value_i,
    input  logic             ready_i,
    output logic [7:0]       byte_o,
    output logic             valid_o,
    output logic             last_o,
    output logic             done_o
);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [7:0]       byte_q, byte_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] src;
    logic [WIDTH-1:0] shifted;

    // A load may land in the same cycle the previous value's final byte leaves,
    // which lets consecutive phases stream without a gap.
    always_comb begin
        rem_d   = rem_q;
        byte_d  = byte_q;
        valid_d = valid_q;
        last_d  = last_q;
        src     = load_i ? value_i : rem_q;
        shifted = src >> 7;
        if (load_i || (valid_q && ready_i && !last_q)) begin
            rem_d   = shifted;
            byte_d  = {(shifted != '0), src[6:0]};
            valid_d = 1'b1;
            last_d  = (shifted == '0);
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q   <= '0;
            byte_q  <= 8'h00;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            rem_q   <= rem_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign byte_o  = byte_q;
    assign valid_o = valid_q;
    assign last_o  = last_q;
    assign done_o  = valid_q && ready_i && last_q;

endmodule

// File: rtl/proto_field_encoder.sv
// Protobuf field serializer: key varint, then a varint/fixed value or a length varint
// followed by payload pass-through. Define PROTO_ZIGZAG_EN for field_signed zigzag varints.
module proto_field_encoder
    import user_tree_pkg::*;
#(
    parameter int FIELD_NUM_WIDTH = 4,
    parameter int VALUE_WIDTH     = 64,
    parameter int LEN_WIDTH       = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       field_valid,
    output logic                       field_ready,
    input  logic [FIELD_NUM_WIDTH-1:0] field_num,
    input  logic [2:0]                 field_type,
    input  logic [VALUE_WIDTH-1:0]     field_value,
`ifdef PROTO_ZIGZAG_EN
    input  logic                       field_signed,
`endif
    input  logic [7:0]                 pay_data,
    input  logic                       pay_valid,
    output logic                       pay_ready,
    output logic [7:0]                 out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last
);

    enc_state_t             state_q, state_d;
    field_kind_t            kind_q, kind_d;
    field_kind_t            req_kind;
    logic [VALUE_WIDTH-1:0] value_q, value_d;
    logic [VALUE_WIDTH-1:0] fix_q, fix_d;
    logic [3:0]             fix_cnt_q, fix_cnt_d;
    logic [LEN_WIDTH-1:0]   pay_cnt_q, pay_cnt_d;
    logic                   live_q;

    logic                   ser_load;
    logic [VALUE_WIDTH-1:0] ser_value;
    logic [7:0]             ser_byte;
    logic                   ser_valid;
    logic                   ser_last;
    logic                   ser_done;

    logic [VALUE_WIDTH-1:0] varint_value;
    logic [LEN_WIDTH-1:0]   len_value;

`ifdef PROTO_ZIGZAG_EN
    logic signed_q, signed_d;

    assign varint_value = signed_q ? ((value_q << 1) ^ {VALUE_WIDTH{value_q[VALUE_WIDTH-1]}})
                                   : value_q;
`else
    assign varint_value = value_q;
`endif

    assign req_kind  = decode_kind(field_type);
    assign len_value = value_q[LEN_WIDTH-1:0];

    proto_varint_serializer #(
        .WIDTH (VALUE_WIDTH)
    ) u_varint (
        .clk     (clk),
        .rst     (rst),
        .load_i  (ser_load),
        .value_i (ser_value),
        .ready_i (out_ready),
        .byte_o  (ser_byte),
        .valid_o (ser_valid),
        .last_o  (ser_last),
        .done_o  (ser_done)
    );

    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        value_d     = value_q;
        fix_d       = fix_q;
        fix_cnt_d   = fix_cnt_q;
        pay_cnt_d   = pay_cnt_q;
`ifdef PROTO_ZIGZAG_EN
        signed_d    = signed_q;
`endif
        ser_load    = 1'b0;
        ser_value   = '0;
        field_ready = 1'b0;
        pay_ready   = 1'b0;
        out_valid   = 1'b0;
        out_data    = 8'h00;
        out_last    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                field_ready = live_q;
                if (field_valid && live_q) begin
                    kind_d    = req_kind;
                    value_d   = field_value;
`ifdef PROTO_ZIGZAG_EN
                    signed_d  = field_signed;
`endif
                    ser_load  = 1'b1;
                    ser_value = VALUE_WIDTH'({field_num, kind_wire_type(req_kind)});
                    state_d   = ST_KEY;
                end
            end

            ST_KEY: begin
                out_data  = ser_byte;
                out_valid = ser_valid;
                if (ser_done) begin
                    case (kind_q)
                        KIND_VARINT: begin
                            ser_load  = 1'b1;
                            ser_value = varint_value;
                            state_d   = ST_VARINT;
                        end
                        KIND_I64: begin
                            fix_d     = value_q;
                            fix_cnt_d = 4'd8;
                            state_d   = ST_FIXED;
                        end
                        KIND_I32: begin
                            fix_d     = value_q;
                            fix_cnt_d = 4'd4;
                            state_d   = ST_FIXED;
                        end
                        default: begin
                            ser_load  = 1'b1;
                            ser_value = VALUE_WIDTH'(len_value);
                            state_d   = ST_LEN;
                        end
                    endcase
                end
            end

            ST_VARINT: begin
                out_data  = ser_byte;
                out_valid = ser_valid;
                out_last  = ser_last;
                if (ser_done) begin
                    state_d = ST_IDLE;
                end
            end

            // Little-endian: low byte first; fixed32 simply stops after four bytes.
            ST_FIXED: begin
                out_data  = fix_q[7:0];
                out_valid = 1'b1;
                out_last  = (fix_cnt_q == 4'd1);
                if (out_ready) begin
                    fix_d     = fix_q >> 8;
                    fix_cnt_d = fix_cnt_q - 4'd1;
                    if (fix_cnt_q == 4'd1) begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_LEN: begin
                out_data  = ser_byte;
                out_valid = ser_valid;
                out_last  = ser_last && (len_value == '0);
                if (ser_done) begin
                    if (len_value == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        pay_cnt_d = len_value;
                        state_d   = ST_PAYLOAD;
                    end
                end
            end

            ST_PAYLOAD: begin
                out_data  = pay_data;
                out_valid = pay_valid;
                pay_ready = out_ready;
                out_last  = (pay_cnt_q == LEN_WIDTH'(1));
                if (pay_valid && out_ready) begin
                    pay_cnt_d = pay_cnt_q - LEN_WIDTH'(1);
                    if (pay_cnt_q == LEN_WIDTH'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Nothing leaves the encoder while reset is being applied.
        if (rst) begin
            field_ready = 1'b0;
            pay_ready   = 1'b0;
            out_valid   = 1'b0;
            out_data    = 8'h00;
            out_last    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            kind_q    <= KIND_VARINT;
            value_q   <= '0;
            fix_q     <= '0;
            fix_cnt_q <= 4'd0;
            pay_cnt_q <= '0;
            live_q    <= 1'b0;
`ifdef PROTO_ZIGZAG_EN
            signed_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            value_q   <= value_d;
            fix_q     <= fix_d;
            fix_cnt_q <= fix_cnt_d;
            pay_cnt_q <= pay_cnt_d;
            live_q    <= 1'b1;
`ifdef PROTO_ZIGZAG_EN
            signed_q  <= signed_d;
`endif
        end
    end

endmodule

// File: tb/tb_proto_field_encoder.sv
// Directed bench for proto_field_encoder: table of fields with hand-computed byte
// streams, plus reset-mid-field and reset-release sequences.
module tb_proto_field_encoder;

    logic        clk;
    logic        rst;
    logic        field_valid;
    logic        field_ready;
    logic [3:0]  field_num;
    logic [2:0]  field_type;
    logic [63:0] field_value;
`ifdef PROTO_ZIGZAG_EN
    logic        field_signed;
`endif
    logic [7:0]  pay_data;
    logic        pay_valid;
    logic        pay_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    int checkCount;
    int failCount;

    typedef struct packed {
        logic [3:0]       num;
        logic [2:0]       ftype;
        logic [63:0]      value;
        logic             stall;
        logic             sgn;
        int               nbytes;
        logic [0:11][7:0] exp;
    } vec_t;

    vec_t vecs [0:15];
    int   numVecs;

    proto_field_encoder dut (
        .clk          (clk),
        .rst          (rst),
        .field_valid  (field_valid),
        .field_ready  (field_ready),
        .field_num    (field_num),
        .field_type   (field_type),
        .field_value  (field_value),
`ifdef PROTO_ZIGZAG_EN
        .field_signed (field_signed),
`endif
        .pay_data     (pay_data),
        .pay_valid    (pay_valid),
        .pay_ready    (pay_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Expected bytes are written right-justified, first byte leftmost.
    function automatic vec_t mk(input logic [3:0] num, input logic [2:0] ftype, input logic [63:0] value,
                                input logic stall, input logic sgn, input int nbytes, input logic [95:0] bytesRj);
        vec_t v;
        v.num    = num;
        v.ftype  = ftype;
        v.value  = value;
        v.stall  = stall;
        v.sgn    = sgn;
        v.nbytes = nbytes;
        v.exp    = bytesRj << (8 * (12 - nbytes));
        return v;
    endfunction

    // Entered at a falling edge; returns in the idle bubble after the field's last byte.
    task automatic applyStimulus(input vec_t v, input int idx);
        logic [7:0] got [0:15];
        logic       gotLast [0:15];
        int         n;
        int         payN;
        int         payLen;
        int         cyc;
        logic       done;
        logic       held;
        logic [7:0] heldData;
        logic       heldLast;

        payLen = (v.ftype == 3'b000) ? int'(v.value[15:0]) : 0;
        field_num   = v.num;
        field_type  = v.ftype;
        field_value = v.value;
`ifdef PROTO_ZIGZAG_EN
        field_signed = v.sgn;
`endif
        field_valid = 1'b1;
        #1;
        checkOutput($sformatf("v%0d field_ready idle", idx), {63'd0, field_ready}, 64'd1);
        @(negedge clk);
        field_valid = 1'b0;
        field_value = 64'hA5A5_A5A5_A5A5_A5A5;

        n = 0; payN = 0; cyc = 0; done = 1'b0; held = 1'b0;
        heldData = 8'h00; heldLast = 1'b0;
        while (!done && cyc < 200) begin
            out_ready = v.stall ? ((cyc % 2) == 1) : 1'b1;
            pay_valid = 1'b1;
            pay_data  = (payN < payLen) ? v.exp[2 + payN] : 8'hEE;
            #1;
            if (held) begin
                checkOutput($sformatf("v%0d stall data", idx), {56'd0, out_data}, {56'd0, heldData});
                checkOutput($sformatf("v%0d stall last", idx), {63'd0, out_last}, {63'd0, heldLast});
                checkOutput($sformatf("v%0d stall valid", idx), {63'd0, out_valid}, 64'd1);
            end
            checkOutput($sformatf("v%0d field_ready busy", idx), {63'd0, field_ready}, 64'd0);
            held     = out_valid && !out_ready;
            heldData = out_data;
            heldLast = out_last;
            if (pay_valid && pay_ready) payN++;
            if (out_valid && out_ready) begin
                if (n < 16) begin
                    got[n]     = out_data;
                    gotLast[n] = out_last;
                end
                n++;
                if (out_last) done = 1'b1;
            end
            cyc++;
            @(negedge clk);
        end

        checkOutput($sformatf("v%0d completed", idx), {63'd0, done}, 64'd1);
        checkOutput($sformatf("v%0d byte count", idx), 64'(n), 64'(v.nbytes));
        checkOutput($sformatf("v%0d payload transfers", idx), 64'(payN), 64'(payLen));
        for (int i = 0; i < v.nbytes && i < n && i < 16; i++) begin
            checkOutput($sformatf("v%0d byte%0d", idx, i), {56'd0, got[i]}, {56'd0, v.exp[i]});
            checkOutput($sformatf("v%0d last%0d", idx, i), {63'd0, gotLast[i]}, (i == v.nbytes - 1) ? 64'd1 : 64'd0);
        end
        out_ready = 1'b1;
        #1;
        checkOutput($sformatf("v%0d bubble field_ready", idx), {63'd0, field_ready}, 64'd1);
        checkOutput($sformatf("v%0d bubble out_valid", idx), {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        int   cyc;
        logic sawPay;

        checkCount  = 0;
        failCount   = 0;
        rst         = 1'b1;
        field_valid = 1'b0;
        field_num   = 4'd0;
        field_type  = 3'd0;
        field_value = 64'd0;
`ifdef PROTO_ZIGZAG_EN
        field_signed = 1'b0;
`endif
        pay_data    = 8'h00;
        pay_valid   = 1'b1;
        out_ready   = 1'b1;

        numVecs = 0;
        vecs[numVecs++] = mk(4'd1, 3'b100, 64'd150, 1'b0, 1'b0, 3, 96'h08_96_01);
        vecs[numVecs++] = mk(4'd2, 3'b001, 64'h1234_5678, 1'b0, 1'b0, 5, 96'h15_78_56_34_12);
        vecs[numVecs++] = mk(4'd1, 3'b000, 64'd3, 1'b0, 1'b0, 5, 96'h0A_03_61_62_63);
        vecs[numVecs++] = mk(4'd1, 3'b100, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 11,
                             96'h08_FF_FF_FF_FF_FF_FF_FF_FF_FF_01);
        vecs[numVecs++] = mk(4'd3, 3'b010, 64'd0, 1'b0, 1'b0, 9, 96'h19_00_00_00_00_00_00_00_00);
        vecs[numVecs++] = mk(4'd1, 3'b000, 64'd0, 1'b0, 1'b0, 2, 96'h0A_00);
        vecs[numVecs++] = mk(4'd1, 3'b101, 64'd5, 1'b0, 1'b0, 2, 96'h08_05);
        vecs[numVecs++] = mk(4'd15, 3'b011, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0, 9,
                             96'h79_EF_CD_AB_89_67_45_23_01);
        vecs[numVecs++] = mk(4'd4, 3'b100, 64'd0, 1'b0, 1'b0, 2, 96'h20_00);
        vecs[numVecs++] = mk(4'd2, 3'b100, 64'd300, 1'b0, 1'b0, 3, 96'h10_AC_02);
        vecs[numVecs++] = mk(4'd5, 3'b001, 64'hDEAD_BEEF_CAFE_BABE, 1'b0, 1'b0, 5, 96'h2D_BE_BA_FE_CA);
        vecs[numVecs++] = mk(4'd6, 3'b000, 64'hFFFF_0000_0000_0002, 1'b1, 1'b0, 4, 96'h32_02_11_22);
`ifdef PROTO_ZIGZAG_EN
        vecs[numVecs++] = mk(4'd1, 3'b100, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 2, 96'h08_01);
        vecs[numVecs++] = mk(4'd1, 3'b100, 64'd1, 1'b0, 1'b1, 2, 96'h08_02);
        vecs[numVecs++] = mk(4'd2, 3'b001, 64'd1, 1'b0, 1'b1, 5, 96'h15_01_00_00_00);
`endif

        // Reset state, with a payload byte already being offered.
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("reset out_data", {56'd0, out_data}, 64'd0);
        checkOutput("reset out_last", {63'd0, out_last}, 64'd0);
        checkOutput("reset field_ready", {63'd0, field_ready}, 64'd0);
        checkOutput("reset pay_ready", {63'd0, pay_ready}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("release field_ready early", {63'd0, field_ready}, 64'd0);
        @(negedge clk);
        #1;
        checkOutput("release field_ready", {63'd0, field_ready}, 64'd1);
        checkOutput("release pay_ready", {63'd0, pay_ready}, 64'd0);

        for (int i = 0; i < numVecs; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Reset after the first payload byte of a 3-byte field.
        field_num   = 4'd1;
        field_type  = 3'b000;
        field_value = 64'd3;
        field_valid = 1'b1;
        @(negedge clk);
        field_valid = 1'b0;
        out_ready   = 1'b1;
        pay_valid   = 1'b1;
        pay_data    = 8'h78;
        sawPay      = 1'b0;
        cyc         = 0;
        while (!sawPay && cyc < 20) begin
            #1;
            sawPay = pay_valid && pay_ready;
            cyc++;
            @(negedge clk);
        end
        checkOutput("midfield first payload byte", {63'd0, sawPay}, 64'd1);
        rst      = 1'b1;
        pay_data = 8'h79;
        #1;
        checkOutput("midfield out_valid in reset", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("midfield out_valid after", {63'd0, out_valid}, 64'd0);
        checkOutput("midfield field_ready at release", {63'd0, field_ready}, 64'd0);
        checkOutput("midfield pay_ready after", {63'd0, pay_ready}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checkOutput($sformatf("midfield quiet%0d", i), {63'd0, out_valid}, 64'd0);
            checkOutput($sformatf("midfield ready%0d", i), {63'd0, field_ready}, 64'd1);
        end

        // Encoder must recover cleanly with a fresh field.
        applyStimulus(vecs[0], 100);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
